// File: rtl/am_best_move_reader.sv
// Depth-1 best-move picker: walks the all_moves list with RAM wait states and keeps the best score.
// Optional feature: AM_READER_TIEBREAK_EN (random_bit breaks equal-score ties).
module am_best_move_reader #(
    parameter int MAX_POSITIONS_LOG2 = 7,
    parameter int EVAL_WIDTH         = 24,
    parameter int UCI_WIDTH          = 16,
    parameter int READ_LATENCY       = 2
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 start,
    input  logic                                 white_to_move_in,
    input  logic                                 am_moves_ready,
    input  logic        [MAX_POSITIONS_LOG2-1:0] am_move_count,
    input  logic signed [EVAL_WIDTH-1:0]         eval_out,
    input  logic        [UCI_WIDTH-1:0]          uci_out,
    input  logic                                 thrice_rep_out,
    input  logic                                 random_bit,
    output logic        [MAX_POSITIONS_LOG2-1:0] am_move_index,
    output logic                                 am_clear_moves,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 no_moves,
    output logic        [MAX_POSITIONS_LOG2-1:0] best_index,
    output logic        [UCI_WIDTH-1:0]          best_uci,
    output logic signed [EVAL_WIDTH-1:0]         best_eval
);
    localparam int MPL2 = MAX_POSITIONS_LOG2;
    localparam int EW   = EVAL_WIDTH;

    typedef enum logic [2:0] {IDLE, WAIT_READY, WAIT_RD, SAMPLE, CLEAR, DONE} state_t;

    state_t            state;
    logic              wtm;
    logic [MPL2-1:0]   count;
    logic [2:0]        wcnt;
    logic signed [EW-1:0] score;
    logic [MPL2:0]     next_idx;
    logic              tie;
    logic              take;

    always_comb begin
        score    = thrice_rep_out ? '0 : eval_out;
        next_idx = {1'b0, am_move_index} + (MPL2+1)'(1);
`ifdef AM_READER_TIEBREAK_EN
        tie      = (score == best_eval) && random_bit;
`else
        // random_bit is referenced only to keep it from dangling; ties keep the earlier move
        tie      = (score == best_eval) & random_bit & 1'b0;
`endif
        take     = (am_move_index == '0) || tie ||
                   (wtm ? (score > best_eval) : (score < best_eval));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            wtm            <= 1'b0;
            count          <= '0;
            wcnt           <= '0;
            am_move_index  <= '0;
            am_clear_moves <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            no_moves       <= 1'b0;
            best_index     <= '0;
            best_uci       <= '0;
            best_eval      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state         <= WAIT_READY;
                        busy          <= 1'b1;
                        wtm           <= white_to_move_in;
                        best_index    <= '0;
                        best_uci      <= '0;
                        best_eval     <= '0;
                        no_moves      <= 1'b0;
                        am_move_index <= '0;
                    end
                end
                WAIT_READY: begin
                    if (am_moves_ready) begin
                        count <= am_move_count;
                        if (am_move_count == '0) begin
                            no_moves       <= 1'b1;
                            am_clear_moves <= 1'b1;
                            state          <= CLEAR;
                        end else begin
                            am_move_index <= '0;
                            wcnt          <= '0;
                            state         <= WAIT_RD;
                        end
                    end
                end
                WAIT_RD: begin
                    if (wcnt == 3'(READ_LATENCY - 1)) state <= SAMPLE;
                    else                              wcnt  <= wcnt + 3'd1;
                end
                SAMPLE: begin
                    if (take) begin
                        best_index <= am_move_index;
                        best_uci   <= uci_out;
                        best_eval  <= score;
                    end
                    // widened compare so a full-range count never wraps
                    if (next_idx < {1'b0, count}) begin
                        am_move_index <= next_idx[MPL2-1:0];
                        wcnt          <= '0;
                        state         <= WAIT_RD;
                    end else begin
                        am_clear_moves <= 1'b1;
                        state          <= CLEAR;
                    end
                end
                CLEAR: begin
                    am_clear_moves <= 1'b0;
                    done           <= 1'b1;
                    busy           <= 1'b0;
                    state          <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_am_best_move_reader.sv
// Bench for am_best_move_reader: directed vector table, hand-written reset sequence, and
// randomized move lists checked against a list-scanning reference model.
module tb_am_best_move_reader;
    localparam int RL = 2;
`ifdef AM_READER_TIEBREAK_EN
    localparam bit TIE = 1'b1;
`else
    localparam bit TIE = 1'b0;
`endif

    logic clk = 1'b0, reset = 1'b1, start = 1'b0, white_to_move_in = 1'b0;
    logic am_moves_ready = 1'b0, thrice_rep_out, random_bit = 1'b0;
    logic [6:0] am_move_count = '0, am_move_index, best_index;
    logic signed [23:0] eval_out, best_eval;
    logic [15:0] uci_out, best_uci;
    logic am_clear_moves, busy, done, no_moves;

    int errors = 0, checks = 0;

    logic signed [23:0] mv_eval [128];
    logic [15:0]        mv_uci  [128];
    logic               mv_rep  [128];
    logic [6:0]         rd_pipe [RL];

    always #5 clk = ~clk;

    // move RAM: data appears RL cycles after the index changes
    always @(posedge clk) begin
        rd_pipe[0] <= am_move_index;
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign eval_out       = mv_eval[rd_pipe[RL-1]];
    assign uci_out        = mv_uci[rd_pipe[RL-1]];
    assign thrice_rep_out = mv_rep[rd_pipe[RL-1]];

    am_best_move_reader #(.READ_LATENCY(RL)) dut (
        .clk(clk), .reset(reset), .start(start), .white_to_move_in(white_to_move_in),
        .am_moves_ready(am_moves_ready), .am_move_count(am_move_count), .eval_out(eval_out),
        .uci_out(uci_out), .thrice_rep_out(thrice_rep_out), .random_bit(random_bit),
        .am_move_index(am_move_index), .am_clear_moves(am_clear_moves), .busy(busy),
        .done(done), .no_moves(no_moves), .best_index(best_index), .best_uci(best_uci),
        .best_eval(best_eval)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic void model(input int cnt, input bit wtm, input bit rb,
                                  output int bi, output logic signed [23:0] be);
        logic signed [23:0] s;
        bi = 0; be = '0;
        for (int i = 0; i < cnt; i++) begin
            s = mv_rep[i] ? 24'sd0 : mv_eval[i];
            if (i == 0 || (wtm && s > be) || (!wtm && s < be) || (TIE && rb && s == be)) begin
                bi = i; be = s;
            end
        end
    endfunction

    task automatic run_list(input int cnt, input bit wtm, input bit rb, input string nm,
                            input int ei, input logic signed [23:0] ee);
        int clr = 0, cyc = 0;
        bit got = 0, prev_clr = 0;
        @(negedge clk);
        white_to_move_in = wtm; random_bit = rb; am_moves_ready = 1'b0;
        am_move_count = 7'(cnt); start = 1'b1;
        @(negedge clk);
        start = 1'b0; white_to_move_in = ~wtm;
        chk({nm, " busy"}, busy, 1);
        repeat (3) @(negedge clk);
        chk({nm, " early_clear"}, am_clear_moves, 0);
        am_moves_ready = 1'b1;
        while (!got && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 4) am_moves_ready = 1'b0;
            if (cyc == 5 && cnt >= 3) start = 1'b1;
            if (cyc == 6) start = 1'b0;
            if (am_clear_moves) clr++;
            if (done) begin
                got = 1;
                chk({nm, " clear_before_done"}, prev_clr, 1);
            end
            prev_clr = am_clear_moves;
        end
        start = 1'b0;
        chk({nm, " done_seen"}, got, 1);
        chk({nm, " clear_pulses"}, clr, 1);
        chk({nm, " busy_at_done"}, busy, 0);
        chk({nm, " no_moves"}, no_moves, cnt == 0);
        chk({nm, " best_index"}, best_index, ei);
        chk({nm, " best_eval"}, longint'(best_eval), longint'(ee));
        chk({nm, " best_uci"}, best_uci, cnt == 0 ? 0 : mv_uci[ei]);
        @(negedge clk);
        chk({nm, " done_len"}, done, 0);
        chk({nm, " eval_held"}, longint'(best_eval), longint'(ee));
    endtask

    typedef struct packed {
        logic [2:0]        cnt;
        logic [3:0][23:0]  ev;
        logic [3:0]        rep;
        logic              wtm;
        logic              rb;
        logic [2:0]        ei;
        logic signed [23:0] ee;
    } vec_t;

    vec_t vt [8];

    initial begin
        int ei;
        logic signed [23:0] ee;
        bit seen_clr;
        int cyc;

        for (int i = 0; i < 128; i++) begin
            mv_eval[i] = '0; mv_rep[i] = 1'b0; mv_uci[i] = 16'(i * 331 + 17);
        end
        // ev entries listed index 3..0
        vt[0] = '{3, {24'sd0, -24'sd5, 24'sd40, 24'sd10}, 4'b0000, 1, 0, 1, 24'sd40};
        vt[1] = '{3, {24'sd0, -24'sd5, 24'sd40, 24'sd10}, 4'b0000, 0, 0, 2, -24'sd5};
        vt[2] = '{0, {24'sd0, 24'sd0, 24'sd0, 24'sd0},    4'b0000, 1, 0, 0, 24'sd0};
        vt[3] = '{2, {24'sd0, 24'sd0, -24'sd100, -24'sd100}, 4'b0010, 1, 0, 1, 24'sd0};
        vt[4] = '{2, {24'sd0, 24'sd0, 24'sd7, 24'sd7},    4'b0000, 1, 1, TIE ? 1 : 0, 24'sd7};
        vt[5] = '{2, {24'sd0, 24'sd0, 24'sd7, 24'sd7},    4'b0000, 0, 0, 0, 24'sd7};
        vt[6] = '{2, {24'sd0, 24'sd0, 24'sh7fffff, 24'sh800000}, 4'b0000, 1, 0, 1, 24'sh7fffff};
        vt[7] = '{2, {24'sd0, 24'sd0, 24'sh7fffff, 24'sh800000}, 4'b0000, 0, 0, 0, 24'sh800000};

        repeat (3) @(negedge clk);
        chk("rst busy", busy, 0);
        chk("rst index", am_move_index, 0);
        chk("rst done", done, 0);
        chk("rst clear", am_clear_moves, 0);
        chk("rst best_eval", longint'(best_eval), 0);
        reset = 1'b0;

        for (int v = 0; v < 8; v++) begin
            for (int j = 0; j < 4; j++) begin
                mv_eval[j] = vt[v].ev[j]; mv_rep[j] = vt[v].rep[j];
            end
            run_list(int'(vt[v].cnt), vt[v].wtm, vt[v].rb, $sformatf("vec%0d", v),
                     int'(vt[v].ei), vt[v].ee);
        end

        // reset in the middle of a 5-move walk
        for (int j = 0; j < 5; j++) begin
            mv_eval[j] = 24'(j * 9 - 20); mv_rep[j] = 1'b0;
        end
        @(negedge clk);
        white_to_move_in = 1'b1; am_move_count = 7'd5; am_moves_ready = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen_clr = 0; cyc = 0;
        while (am_move_index != 7'd2 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (am_clear_moves) seen_clr = 1;
        end
        chk("midrst reached_index2", am_move_index, 2);
        reset = 1'b1;
        #1;
        chk("midrst busy", busy, 0);
        chk("midrst index", am_move_index, 0);
        chk("midrst best_eval", longint'(best_eval), 0);
        chk("midrst best_index", best_index, 0);
        chk("midrst clear", am_clear_moves | seen_clr, 0);
        @(negedge clk);
        reset = 1'b0;
        model(5, 1, 0, ei, ee);
        run_list(5, 1, 0, "after_rst", ei, ee);

        // randomized lists; small eval ranges in some runs to provoke ties
        for (int r = 0; r < 20; r++) begin
            int cnt;
            bit wtm, rb, narrow;
            cnt = (r == 19) ? 127 : int'($urandom_range(0, 12));
            wtm = 1'($urandom); rb = 1'($urandom); narrow = 1'($urandom);
            for (int j = 0; j < cnt; j++) begin
                mv_eval[j] = narrow ? 24'($signed($urandom_range(0, 4)) - 2) : 24'($urandom);
                mv_rep[j]  = ($urandom_range(0, 3) == 0);
                mv_uci[j]  = 16'($urandom);
            end
            model(cnt, wtm, rb, ei, ee);
            run_list(cnt, wtm, rb, $sformatf("rand%0d", r), ei, ee);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
